// File: rtl/toggle_stim_pkg.sv
// Shared state encoding and default timing for the toggle stimulus generator.
// Also provides a constant helper used to size the phase counter.
package toggle_stim_pkg;

  localparam int DEF_PH0_CYC    = 2;
  localparam int DEF_PH1_CYC    = 4;
  localparam int DEF_PH2_CYC    = 4;
  localparam int DEF_NUM_PULSES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH0,
    ST_PH1,
    ST_PH2,
    ST_PULSE_HI,
    ST_PULSE_LO,
    ST_DONE
  } state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/stim_phase_counter.sv
// Loadable down-counter with terminal-count flag; load wins over decrement.
// tc is combinational from the count register; no backpressure.
module stim_phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/toggle_stim_gen.sv
// Drives reset/enable stimulus to a toggle DUT and counts q rising edges in the pulse phase.
// Outputs registered from next-state (0 cycles after state); q edges counted 2 cycles after sampling; start ignored while busy.
module toggle_stim_gen
  import toggle_stim_pkg::*;
#(
  parameter int PH0_CYC    = DEF_PH0_CYC,
  parameter int PH1_CYC    = DEF_PH1_CYC,
  parameter int PH2_CYC    = DEF_PH2_CYC,
  parameter int NUM_PULSES = DEF_NUM_PULSES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       q,
  output logic       busy,
  output logic       done,
  output logic       dut_reset,
  output logic       dut_en,
  output logic [7:0] q_rise_cnt
);

  localparam int CNT_W = $clog2(max4(PH0_CYC, PH1_CYC, PH2_CYC, NUM_PULSES) + 1);
  localparam logic [CNT_W-1:0] PH0_LD = CNT_W'(PH0_CYC - 1);
  localparam logic [CNT_W-1:0] PH1_LD = CNT_W'(PH1_CYC - 1);
  localparam logic [CNT_W-1:0] PH2_LD = CNT_W'(PH2_CYC - 1);
  localparam logic [CNT_W-1:0] PLS_LD = CNT_W'(NUM_PULSES - 1);

  state_t             state;
  state_t             state_nxt;
  logic               ph_load;
  logic [CNT_W-1:0]   ph_load_val;
  logic               ph_dec;
  logic               ph_tc;
  logic               clr_cnt;
  logic               q_s1;
  logic               q_s2;
  logic               q_s3;
  logic               q_rise;
  logic               in_pulse;

  // One counter times every phase; in the pulse phase it counts remaining pairs.
  stim_phase_counter #(
    .W (CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_load_val),
    .dec      (ph_dec),
    .tc       (ph_tc)
  );

  always_comb begin
    state_nxt   = state;
    ph_load     = 1'b0;
    ph_load_val = '0;
    ph_dec      = 1'b0;
    clr_cnt     = 1'b0;
    if ((state != ST_IDLE) && abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state_nxt   = ST_PH0;
            ph_load     = 1'b1;
            ph_load_val = PH0_LD;
            clr_cnt     = 1'b1;
          end
        end
        ST_PH0: begin
          if (ph_tc) begin
            state_nxt   = ST_PH1;
            ph_load     = 1'b1;
            ph_load_val = PH1_LD;
          end else begin
            ph_dec = 1'b1;
          end
        end
        ST_PH1: begin
          if (ph_tc) begin
            state_nxt   = ST_PH2;
            ph_load     = 1'b1;
            ph_load_val = PH2_LD;
          end else begin
            ph_dec = 1'b1;
          end
        end
        ST_PH2: begin
          if (ph_tc) begin
            state_nxt   = ST_PULSE_HI;
            ph_load     = 1'b1;
            ph_load_val = PLS_LD;
          end else begin
            ph_dec = 1'b1;
          end
        end
        ST_PULSE_HI: state_nxt = ST_PULSE_LO;
        ST_PULSE_LO: begin
          if (ph_tc) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_PULSE_HI;
            ph_dec    = 1'b1;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs decode next-state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      dut_reset <= 1'b0;
      dut_en    <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
      dut_reset <= (state_nxt == ST_PH1);
      dut_en    <= (state_nxt == ST_PULSE_HI);
    end
  end

  assign q_rise   = q_s2 && !q_s3;
  assign in_pulse = (state == ST_PULSE_HI) || (state == ST_PULSE_LO);

  // q_s1/q_s2 synchronise q; q_s3 holds the previous synchronised sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_s1       <= 1'b0;
      q_s2       <= 1'b0;
      q_s3       <= 1'b0;
      q_rise_cnt <= 8'd0;
    end else begin
      q_s1 <= q;
      q_s2 <= q_s1;
      q_s3 <= q_s2;
      if (clr_cnt) begin
        q_rise_cnt <= 8'd0;
      end else if (in_pulse && q_rise && (q_rise_cnt != 8'hFF)) begin
        q_rise_cnt <= q_rise_cnt + 8'd1;
      end
    end
  end

endmodule
